pipemdu: RTL and testbench

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the EXE stage of the five-stage pipelined MIPS CPU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EXE, computes iteratively over 32 cycles, and writes HI/LO. It serves MFHI/MFLO reads and raises a stall whenever EXE needs the unit while it is busy.

---
 rtl/pipemdu.sv | 166 ++++++++++++++++
 tb/tb_pipemdu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipemdu.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO, placed beside EXE.
// One shift-add or restoring-divide step per cycle; results commit to HI/LO only in DONE.
module pipemdu (
  input  logic        clock,
  input  logic        resetn,
  input  logic        estart,
  input  logic [2:0]  emdop,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic        erdhilo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        mdstall,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  // Handshake: EXE presents estart/emdop/ea/eb and holds them while mdstall is high;
  // the request is consumed at the first rising edge where the unit is IDLE.

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic [31:0] acc;      // product high half / partial remainder
  logic [31:0] low;      // multiplier then product low half / dividend then quotient
  logic [31:0] opnd;     // multiplicand magnitude / divisor magnitude
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;
  logic        div0;
  logic [31:0] hi_q, lo_q;

  logic        idle, start_calc, wr_mthi, wr_mtlo;
  logic        op_signed, sa, sb;
  logic [31:0] mag_a, mag_b;

  assign idle       = (state == IDLE);
  assign start_calc = idle & estart & ~emdop[2];
  assign wr_mthi    = idle & estart & (emdop == OP_MTHI);
  assign wr_mtlo    = idle & estart & (emdop == OP_MTLO);

  // MULT (0) and DIV (2) are the signed encodings.
  assign op_signed = ~emdop[0];
  assign sa        = op_signed & ea[31];
  assign sb        = op_signed & eb[31];
  assign mag_a     = sa ? (~ea + 32'd1) : ea;
  assign mag_b     = sb ? (~eb + 32'd1) : eb;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_calc) state_nx = CALC;
      CALC:    if (cnt == 6'd31) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One iteration of either algorithm, selected by is_div.
  logic [32:0] add_sum;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] acc_nx, low_nx;

  always_comb begin
    add_sum = {1'b0, acc} + {1'b0, opnd};
    shifted = {acc, low[31]};
    diff    = shifted - {1'b0, opnd};
    acc_nx  = acc;
    low_nx  = low;
    if (is_div) begin
      // Borrow in bit 32 means the trial subtraction failed: restore.
      if (!diff[32]) begin
        acc_nx = diff[31:0];
        low_nx = {low[30:0], 1'b1};
      end else begin
        acc_nx = shifted[31:0];
        low_nx = {low[30:0], 1'b0};
      end
    end else begin
      if (low[0]) begin
        acc_nx = add_sum[32:1];
        low_nx = {add_sum[0], low[31:1]};
      end else begin
        acc_nx = {1'b0, acc[31:1]};
        low_nx = {acc[0], low[31:1]};
      end
    end
  end

  // Sign fix applied at commit.
  logic [63:0] prod, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    prod     = {acc, low};
    prod_fix = neg_res ? (~prod + 64'd1) : prod;
    quo_fix  = neg_res ? (~low + 32'd1) : low;
    rem_fix  = neg_rem ? (~acc + 32'd1) : acc;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt     <= 6'd0;
      acc     <= 32'd0;
      low     <= 32'd0;
      opnd    <= 32'd0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else if (start_calc) begin
      cnt     <= 6'd0;
      acc     <= 32'd0;
      is_div  <= emdop[1];
      low     <= emdop[1] ? mag_a : mag_b;
      opnd    <= emdop[1] ? mag_b : mag_a;
      div0    <= emdop[1] & (eb == 32'd0);
      // A zero divisor leaves the all-ones quotient un-negated.
      neg_res <= (sa ^ sb) & ~(emdop[1] & (eb == 32'd0));
      neg_rem <= emdop[1] & sa;
    end else if (state == CALC) begin
      cnt <= cnt + 6'd1;
      acc <= acc_nx;
      low <= low_nx;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (state == DONE) begin
      if (is_div) begin
        hi_q <= rem_fix;
        lo_q <= div0 ? 32'hFFFF_FFFF : quo_fix;
      end else begin
        hi_q <= prod_fix[63:32];
        lo_q <= prod_fix[31:0];
      end
    end else begin
      if (wr_mthi) hi_q <= ea;
      if (wr_mtlo) lo_q <= ea;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = ~idle;
  assign mdstall   = busy & (estart | erdhilo);
  assign dbg_state = state;

endmodule

// File: tb/tb_pipemdu.sv
// Directed bench for pipemdu: hand-computed HI/LO results, latency, stall and reset behaviour.
module tb_pipemdu;

  logic        clock;
  logic        resetn;
  logic        estart;
  logic [2:0]  emdop;
  logic [31:0] ea, eb;
  logic        erdhilo;
  logic [31:0] hi, lo;
  logic        busy, mdstall;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi, m_lo;   // bench's view of committed HI/LO
  int cyc;

  pipemdu dut (
    .clock     (clock),
    .resetn    (resetn),
    .estart    (estart),
    .emdop     (emdop),
    .ea        (ea),
    .eb        (eb),
    .erdhilo   (erdhilo),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .mdstall   (mdstall),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one arithmetic op, scramble operands during CALC, then check latency and result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    estart = 1'b1; emdop = op; ea = a; eb = b;
    step();
    estart = 1'b0; emdop = 3'd6; ea = $urandom; eb = $urandom;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 16) begin
        check({tag, "_mid_hi"}, hi, m_hi);
        check({tag, "_mid_lo"}, lo, m_lo);
      end
      step();
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd33);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    resetn = 1'b0; estart = 1'b0; emdop = 3'd6; ea = '0; eb = '0; erdhilo = 1'b0;
    m_hi = '0; m_lo = '0;
    #12;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_mdstall", {31'd0, mdstall}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    step();
    resetn = 1'b1;
    step();

    // Arithmetic results and 33-cycle latency
    run_op("mult_neg3x5",  3'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu_max",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_m1xm1",   3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    run_op("divu_100_7",   3'd3, 32'd100,       32'd7,         32'd2,         32'd14);
    run_op("div_m7_2",     3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_by_zero",  3'd2, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div_overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // MTHI at idle writes in one edge; no-op encoding changes nothing
    estart = 1'b1; emdop = 3'd4; ea = 32'h0000_0055;
    step();
    check("mthi_hi", hi, 32'h0000_0055);
    check("mthi_lo", lo, 32'h8000_0000);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    emdop = 3'd7; ea = 32'hDEAD_BEEF;
    step();
    estart = 1'b0;
    check("noop_hi", hi, 32'h0000_0055);
    check("noop_busy", {31'd0, busy}, 32'd0);

    // MFLO stalls from the cycle after acceptance until commit
    estart = 1'b1; emdop = 3'd1; ea = 32'd3; eb = 32'd4;
    step();
    estart = 1'b0; erdhilo = 1'b1;
    cyc = 0;
    while (mdstall && cyc < 100) begin
      cyc++;
      step();
    end
    check("mflo_stall_cycles", 32'(cyc), 32'd33);
    check("mflo_lo", lo, 32'd12);
    check("mflo_hi", hi, 32'd0);
    check("mflo_mdstall_after", {31'd0, mdstall}, 32'd0);
    erdhilo = 1'b0;

    // MTLO while busy waits for the commit, then overrides LO
    estart = 1'b1; emdop = 3'd1; ea = 32'd3; eb = 32'd4;
    step();
    emdop = 3'd5; ea = 32'h0000_00AA;
    check("mtlo_stall", {31'd0, mdstall}, 32'd1);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      step();
    end
    check("mtlo_commit_lo", lo, 32'd12);
    check("mtlo_commit_stall", {31'd0, mdstall}, 32'd0);
    step();
    estart = 1'b0; emdop = 3'd6;
    check("mtlo_lo", lo, 32'h0000_00AA);
    check("mtlo_hi", hi, 32'd0);
    check("mtlo_busy", {31'd0, busy}, 32'd0);

    // Back-to-back: second op held during busy, accepted at the first IDLE edge, once
    estart = 1'b1; emdop = 3'd1; ea = 32'd2; eb = 32'd3;
    step();
    emdop = 3'd3; ea = 32'd100; eb = 32'd7;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      step();
    end
    check("b2b_first_cycles", 32'(cyc), 32'd33);
    check("b2b_first_lo", lo, 32'd6);
    check("b2b_first_hi", hi, 32'd0);
    check("b2b_idle_stall", {31'd0, mdstall}, 32'd0);
    step();
    estart = 1'b0; emdop = 3'd6;
    check("b2b_second_busy", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      step();
    end
    check("b2b_second_cycles", 32'(cyc), 32'd33);
    check("b2b_second_lo", lo, 32'd14);
    check("b2b_second_hi", hi, 32'd2);
    step();
    check("b2b_no_requeue", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-divide aborts without a partial write
    estart = 1'b1; emdop = 3'd3; ea = 32'd100; eb = 32'd7;
    step();
    estart = 1'b0; emdop = 3'd6;
    repeat (10) step();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    step();
    resetn = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    step();
    run_op("post_reset_multu", 3'd1, 32'd2, 32'd3, 32'd0, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
